// File: rtl/axi_mem_window_guard.sv
// AXI4 firewall for the core memory path: in-window bursts are forwarded untouched,
// out-of-window bursts are absorbed and answered locally with DECERR in ID order.
module axi_mem_window_guard #(
    parameter int              ADDR_W   = 32,
    parameter int              DATA_W   = 64,
    parameter int              ID_W     = 1,
    parameter logic [31:0]     WIN_BASE = 32'h8000_0000,
    parameter logic [31:0]     WIN_SIZE = 32'h1000_0000,
    parameter int              MAX_OUTS = 8
) (
    input  logic                uncoreclk,
    input  logic                uncore_rstn,
    input  logic [ID_W-1:0]     s_axi_awid,
    input  logic [ADDR_W-1:0]   s_axi_awaddr,
    input  logic [7:0]          s_axi_awlen,
    input  logic [2:0]          s_axi_awsize,
    input  logic [1:0]          s_axi_awburst,
    input  logic                s_axi_awvalid,
    output logic                s_axi_awready,
    input  logic [DATA_W-1:0]   s_axi_wdata,
    input  logic [DATA_W/8-1:0] s_axi_wstrb,
    input  logic                s_axi_wlast,
    input  logic                s_axi_wvalid,
    output logic                s_axi_wready,
    output logic [ID_W-1:0]     s_axi_bid,
    output logic [1:0]          s_axi_bresp,
    output logic                s_axi_bvalid,
    input  logic                s_axi_bready,
    input  logic [ID_W-1:0]     s_axi_arid,
    input  logic [ADDR_W-1:0]   s_axi_araddr,
    input  logic [7:0]          s_axi_arlen,
    input  logic [2:0]          s_axi_arsize,
    input  logic [1:0]          s_axi_arburst,
    input  logic                s_axi_arvalid,
    output logic                s_axi_arready,
    output logic [ID_W-1:0]     s_axi_rid,
    output logic [DATA_W-1:0]   s_axi_rdata,
    output logic [1:0]          s_axi_rresp,
    output logic                s_axi_rlast,
    output logic                s_axi_rvalid,
    input  logic                s_axi_rready,
    output logic [ID_W-1:0]     m_axi_awid,
    output logic [ADDR_W-1:0]   m_axi_awaddr,
    output logic [7:0]          m_axi_awlen,
    output logic [2:0]          m_axi_awsize,
    output logic [1:0]          m_axi_awburst,
    output logic                m_axi_awvalid,
    input  logic                m_axi_awready,
    output logic [DATA_W-1:0]   m_axi_wdata,
    output logic [DATA_W/8-1:0] m_axi_wstrb,
    output logic                m_axi_wlast,
    output logic                m_axi_wvalid,
    input  logic                m_axi_wready,
    input  logic [ID_W-1:0]     m_axi_bid,
    input  logic [1:0]          m_axi_bresp,
    input  logic                m_axi_bvalid,
    output logic                m_axi_bready,
    output logic [ID_W-1:0]     m_axi_arid,
    output logic [ADDR_W-1:0]   m_axi_araddr,
    output logic [7:0]          m_axi_arlen,
    output logic [2:0]          m_axi_arsize,
    output logic [1:0]          m_axi_arburst,
    output logic                m_axi_arvalid,
    input  logic                m_axi_arready,
    input  logic [ID_W-1:0]     m_axi_rid,
    input  logic [DATA_W-1:0]   m_axi_rdata,
    input  logic [1:0]          m_axi_rresp,
    input  logic                m_axi_rlast,
    input  logic                m_axi_rvalid,
    output logic                m_axi_rready,
    output logic [15:0]         err_count,
    output logic [ADDR_W-1:0]   err_addr,
    output logic                err_is_write
);
    localparam int CNT_W = $clog2(MAX_OUTS) + 1;
    localparam int XW    = ADDR_W + 2;
    localparam logic [XW-1:0] WIN_LO = XW'(WIN_BASE);
    localparam logic [XW-1:0] WIN_HI = XW'(WIN_BASE) + XW'(WIN_SIZE);

    typedef enum logic [2:0] {W_IDLE, W_PASS, W_DRAIN, W_WAIT, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_ERR} r_state_t;

    w_state_t          w_state_q, w_state_d;
    r_state_t          r_state_q, r_state_d;
    logic [CNT_W-1:0]  outs_w_q, outs_w_d, outs_r_q, outs_r_d;
    logic [ID_W-1:0]   w_id_q, w_id_d, r_id_q, r_id_d;
    logic [7:0]        r_len_q, r_len_d, r_beat_q, r_beat_d;
    logic [15:0]       err_count_q, err_count_d;
    logic [ADDR_W-1:0] err_addr_q, err_addr_d;
    logic              err_is_write_q, err_is_write_d;
    logic              aw_rej, ar_rej, aw_legal, ar_legal;
    logic [16:0]       err_sum;

    // Burst end is computed two bits wider than the address so a burst near the top never wraps into range.
    function automatic logic in_window(input logic [ADDR_W-1:0] addr, input logic [7:0] len,
                                       input logic [2:0] size);
        logic [XW-1:0] bytes;
        logic [XW-1:0] last_excl;
        bytes     = XW'({1'b0, len} + 9'd1) << size;
        last_excl = XW'(addr) + bytes;
        return (XW'(addr) >= WIN_LO) && (last_excl <= WIN_HI);
    endfunction

    assign aw_legal = in_window(s_axi_awaddr, s_axi_awlen, s_axi_awsize);
    assign ar_legal = in_window(s_axi_araddr, s_axi_arlen, s_axi_arsize);

    assign m_axi_awid    = s_axi_awid;
    assign m_axi_awaddr  = s_axi_awaddr;
    assign m_axi_awlen   = s_axi_awlen;
    assign m_axi_awsize  = s_axi_awsize;
    assign m_axi_awburst = s_axi_awburst;
    assign m_axi_wdata   = s_axi_wdata;
    assign m_axi_wstrb   = s_axi_wstrb;
    assign m_axi_wlast   = s_axi_wlast;
    assign m_axi_arid    = s_axi_arid;
    assign m_axi_araddr  = s_axi_araddr;
    assign m_axi_arlen   = s_axi_arlen;
    assign m_axi_arsize  = s_axi_arsize;
    assign m_axi_arburst = s_axi_arburst;

    // Handshake muxing; every valid/ready is forced low while reset is held.
    always_comb begin
        s_axi_awready = 1'b0;
        m_axi_awvalid = 1'b0;
        s_axi_wready  = 1'b0;
        m_axi_wvalid  = 1'b0;
        s_axi_bvalid  = 1'b0;
        s_axi_bid     = m_axi_bid;
        s_axi_bresp   = m_axi_bresp;
        m_axi_bready  = 1'b0;
        s_axi_arready = 1'b0;
        m_axi_arvalid = 1'b0;
        s_axi_rvalid  = 1'b0;
        s_axi_rid     = m_axi_rid;
        s_axi_rdata   = m_axi_rdata;
        s_axi_rresp   = m_axi_rresp;
        s_axi_rlast   = m_axi_rlast;
        m_axi_rready  = 1'b0;
        aw_rej        = 1'b0;
        ar_rej        = 1'b0;
        if (uncore_rstn) begin
            s_axi_bvalid = m_axi_bvalid;
            m_axi_bready = s_axi_bready;
            s_axi_rvalid = m_axi_rvalid;
            m_axi_rready = s_axi_rready;
            case (w_state_q)
                W_IDLE: if (s_axi_awvalid) begin
                    if (!aw_legal) begin
                        s_axi_awready = 1'b1;
                        aw_rej        = 1'b1;
                    end else if (outs_w_q < CNT_W'(MAX_OUTS)) begin
                        m_axi_awvalid = 1'b1;
                        s_axi_awready = m_axi_awready;
                    end
                end
                W_PASS: begin
                    m_axi_wvalid = s_axi_wvalid;
                    s_axi_wready = m_axi_wready;
                end
                W_DRAIN: s_axi_wready = 1'b1;
                W_RESP: begin
                    s_axi_bvalid = 1'b1;
                    s_axi_bid    = w_id_q;
                    s_axi_bresp  = 2'b11;
                    m_axi_bready = 1'b0;
                end
                default: ;
            endcase
            case (r_state_q)
                R_IDLE: if (s_axi_arvalid) begin
                    if (!ar_legal) begin
                        s_axi_arready = 1'b1;
                        ar_rej        = 1'b1;
                    end else if (outs_r_q < CNT_W'(MAX_OUTS)) begin
                        m_axi_arvalid = 1'b1;
                        s_axi_arready = m_axi_arready;
                    end
                end
                R_ERR: begin
                    s_axi_rvalid = 1'b1;
                    s_axi_rid    = r_id_q;
                    s_axi_rdata  = '0;
                    s_axi_rresp  = 2'b11;
                    s_axi_rlast  = (r_beat_q == r_len_q);
                    m_axi_rready = 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_state_d      = w_state_q;
        r_state_d      = r_state_q;
        outs_w_d       = outs_w_q;
        outs_r_d       = outs_r_q;
        w_id_d         = w_id_q;
        r_id_d         = r_id_q;
        r_len_d        = r_len_q;
        r_beat_d       = r_beat_q;
        err_addr_d     = err_addr_q;
        err_is_write_d = err_is_write_q;

        if ((m_axi_awvalid && m_axi_awready) && !(m_axi_bvalid && m_axi_bready))
            outs_w_d = outs_w_q + CNT_W'(1);
        else if (!(m_axi_awvalid && m_axi_awready) && (m_axi_bvalid && m_axi_bready))
            outs_w_d = outs_w_q - CNT_W'(1);
        if ((m_axi_arvalid && m_axi_arready) && !(m_axi_rvalid && m_axi_rready && m_axi_rlast))
            outs_r_d = outs_r_q + CNT_W'(1);
        else if (!(m_axi_arvalid && m_axi_arready) && (m_axi_rvalid && m_axi_rready && m_axi_rlast))
            outs_r_d = outs_r_q - CNT_W'(1);

        case (w_state_q)
            W_IDLE: begin
                if (aw_rej) begin
                    w_id_d    = s_axi_awid;
                    w_state_d = W_DRAIN;
                end else if (m_axi_awvalid && m_axi_awready) begin
                    w_state_d = W_PASS;
                end
            end
            W_PASS:  if (s_axi_wvalid && s_axi_wready && s_axi_wlast) w_state_d = W_IDLE;
            // Skipping W_WAIT when nothing is outstanding gives the one-cycle DECERR latency.
            W_DRAIN: if (s_axi_wvalid && s_axi_wlast)
                         w_state_d = (outs_w_d == '0) ? W_RESP : W_WAIT;
            W_WAIT:  if (outs_w_d == '0) w_state_d = W_RESP;
            W_RESP:  if (s_axi_bready) w_state_d = W_IDLE;
            default: w_state_d = W_IDLE;
        endcase

        case (r_state_q)
            R_IDLE: if (ar_rej) begin
                r_id_d    = s_axi_arid;
                r_len_d   = s_axi_arlen;
                r_beat_d  = '0;
                r_state_d = (outs_r_d == '0) ? R_ERR : R_WAIT;
            end
            R_WAIT: if (outs_r_d == '0) r_state_d = R_ERR;
            R_ERR: if (s_axi_rready) begin
                if (r_beat_q == r_len_q) begin
                    r_beat_d  = '0;
                    r_state_d = R_IDLE;
                end else begin
                    r_beat_d = r_beat_q + 8'd1;
                end
            end
            default: r_state_d = R_IDLE;
        endcase

        // Simultaneous rejections count twice; the write wins the address log.
        err_sum     = {1'b0, err_count_q} + {16'd0, aw_rej} + {16'd0, ar_rej};
        err_count_d = err_sum[16] ? 16'hFFFF : err_sum[15:0];
        if (aw_rej) begin
            err_addr_d     = s_axi_awaddr;
            err_is_write_d = 1'b1;
        end else if (ar_rej) begin
            err_addr_d     = s_axi_araddr;
            err_is_write_d = 1'b0;
        end
    end

    always_ff @(posedge uncoreclk or negedge uncore_rstn) begin
        if (!uncore_rstn) begin
            w_state_q      <= W_IDLE;
            r_state_q      <= R_IDLE;
            outs_w_q       <= '0;
            outs_r_q       <= '0;
            w_id_q         <= '0;
            r_id_q         <= '0;
            r_len_q        <= '0;
            r_beat_q       <= '0;
            err_count_q    <= '0;
            err_addr_q     <= '0;
            err_is_write_q <= 1'b0;
        end else begin
            w_state_q      <= w_state_d;
            r_state_q      <= r_state_d;
            outs_w_q       <= outs_w_d;
            outs_r_q       <= outs_r_d;
            w_id_q         <= w_id_d;
            r_id_q         <= r_id_d;
            r_len_q        <= r_len_d;
            r_beat_q       <= r_beat_d;
            err_count_q    <= err_count_d;
            err_addr_q     <= err_addr_d;
            err_is_write_q <= err_is_write_d;
        end
    end

    assign err_count    = err_count_q;
    assign err_addr     = err_addr_q;
    assign err_is_write = err_is_write_q;
endmodule

// File: tb/tb_axi_mem_window_guard.sv
// Scoreboard bench for axi_mem_window_guard: directed bursts on the upstream side,
// a simple memory responder downstream, and monitors that pop expected responses.
module tb_axi_mem_window_guard;
    logic        uncoreclk = 1'b0;
    logic        uncore_rstn = 1'b0;
    always #5 uncoreclk = ~uncoreclk;

    logic        s_axi_awid, s_axi_awvalid, s_axi_awready;
    logic [31:0] s_axi_awaddr;
    logic [7:0]  s_axi_awlen;
    logic [2:0]  s_axi_awsize;
    logic [1:0]  s_axi_awburst;
    logic [63:0] s_axi_wdata;
    logic [7:0]  s_axi_wstrb;
    logic        s_axi_wlast, s_axi_wvalid, s_axi_wready;
    logic        s_axi_bid, s_axi_bvalid, s_axi_bready;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_arid, s_axi_arvalid, s_axi_arready;
    logic [31:0] s_axi_araddr;
    logic [7:0]  s_axi_arlen;
    logic [2:0]  s_axi_arsize;
    logic [1:0]  s_axi_arburst;
    logic        s_axi_rid, s_axi_rlast, s_axi_rvalid, s_axi_rready;
    logic [63:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        m_axi_awid, m_axi_awvalid, m_axi_awready;
    logic [31:0] m_axi_awaddr;
    logic [7:0]  m_axi_awlen;
    logic [2:0]  m_axi_awsize;
    logic [1:0]  m_axi_awburst;
    logic [63:0] m_axi_wdata;
    logic [7:0]  m_axi_wstrb;
    logic        m_axi_wlast, m_axi_wvalid, m_axi_wready;
    logic        m_axi_bid, m_axi_bvalid, m_axi_bready;
    logic [1:0]  m_axi_bresp;
    logic        m_axi_arid, m_axi_arvalid, m_axi_arready;
    logic [31:0] m_axi_araddr;
    logic [7:0]  m_axi_arlen;
    logic [2:0]  m_axi_arsize;
    logic [1:0]  m_axi_arburst;
    logic        m_axi_rid, m_axi_rlast, m_axi_rvalid, m_axi_rready;
    logic [63:0] m_axi_rdata;
    logic [1:0]  m_axi_rresp;
    logic [15:0] err_count;
    logic [31:0] err_addr;
    logic        err_is_write;

    axi_mem_window_guard dut (
        .uncoreclk(uncoreclk), .uncore_rstn(uncore_rstn),
        .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
        .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst), .s_axi_awvalid(s_axi_awvalid),
        .s_axi_awready(s_axi_awready), .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
        .s_axi_wlast(s_axi_wlast), .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
        .s_axi_bready(s_axi_bready), .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr),
        .s_axi_arlen(s_axi_arlen), .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready), .s_axi_rid(s_axi_rid),
        .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rlast(s_axi_rlast),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
        .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awvalid(m_axi_awvalid),
        .m_axi_awready(m_axi_awready), .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
        .m_axi_wlast(m_axi_wlast), .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
        .m_axi_bready(m_axi_bready), .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr),
        .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready), .m_axi_rid(m_axi_rid),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
        .err_count(err_count), .err_addr(err_addr), .err_is_write(err_is_write)
    );

    int errors = 0;
    int checks = 0;
    logic rd_en = 1'b1;

    logic [31:0] exp_maw[$];
    logic [63:0] exp_mw[$];
    logic [2:0]  exp_b[$];
    logic [67:0] exp_r[$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input string what);
        checks++;
        errors++;
        $display("FAIL %s: got %s", name, what);
    endtask

    function automatic logic [63:0] rd_pat(input logic [31:0] addr, input logic [7:0] beat);
        return {addr, 24'h5A5A5A, beat};
    endfunction

    // Monitors: sampled on the falling edge, so a valid&ready seen here completes on the next rise.
    initial forever begin
        @(negedge uncoreclk);
        if (uncore_rstn) begin
            if (m_axi_awvalid && m_axi_awready) begin
                if (exp_maw.size() == 0) fail_now("m_aw_unexpected", $sformatf("awaddr %0h", m_axi_awaddr));
                else chk("m_aw_addr", 128'(m_axi_awaddr), 128'(exp_maw.pop_front()));
            end
            if (m_axi_wvalid && m_axi_wready) begin
                if (exp_mw.size() == 0) fail_now("m_w_unexpected", $sformatf("wdata %0h", m_axi_wdata));
                else chk("m_w_data", 128'(m_axi_wdata), 128'(exp_mw.pop_front()));
            end
            if (s_axi_bvalid && s_axi_bready) begin
                if (exp_b.size() == 0) fail_now("s_b_unexpected", $sformatf("bid %0h bresp %0h", s_axi_bid, s_axi_bresp));
                else chk("s_b_id_resp", 128'({s_axi_bid, s_axi_bresp}), 128'(exp_b.pop_front()));
            end
            if (s_axi_rvalid && s_axi_rready) begin
                if (exp_r.size() == 0) fail_now("s_r_unexpected", $sformatf("rdata %0h", s_axi_rdata));
                else chk("s_r_beat", 128'({s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast}),
                         128'(exp_r.pop_front()));
            end
        end
    end

    // Downstream memory model: accepts everything, returns OKAY B per burst and patterned read data.
    logic        aw_hs, wl_hs, b_hs, ar_hs, r_hs, aw_id_s;
    logic [40:0] ar_info_s;
    logic        sl_aw_ids[$];
    logic [40:0] sl_ar[$];
    int          sl_wlast_cnt;
    int          sl_beat;
    initial begin
        m_axi_awready = 1'b1; m_axi_wready = 1'b1; m_axi_arready = 1'b1;
        m_axi_bvalid = 1'b0; m_axi_bid = 1'b0; m_axi_bresp = 2'b00;
        m_axi_rvalid = 1'b0; m_axi_rid = 1'b0; m_axi_rdata = '0; m_axi_rresp = 2'b00; m_axi_rlast = 1'b0;
        sl_wlast_cnt = 0; sl_beat = 0;
        forever begin
            @(negedge uncoreclk);
            aw_hs     = m_axi_awvalid && m_axi_awready;
            aw_id_s   = m_axi_awid;
            wl_hs     = m_axi_wvalid && m_axi_wready && m_axi_wlast;
            b_hs      = m_axi_bvalid && m_axi_bready;
            ar_hs     = m_axi_arvalid && m_axi_arready;
            ar_info_s = {m_axi_arid, m_axi_araddr, m_axi_arlen};
            r_hs      = m_axi_rvalid && m_axi_rready;
            @(posedge uncoreclk);
            #1;
            if (!uncore_rstn) begin
                sl_aw_ids.delete(); sl_ar.delete();
                sl_wlast_cnt = 0; sl_beat = 0;
                m_axi_bvalid = 1'b0; m_axi_rvalid = 1'b0;
            end else begin
                if (b_hs) m_axi_bvalid = 1'b0;
                if (aw_hs) sl_aw_ids.push_back(aw_id_s);
                if (wl_hs) sl_wlast_cnt++;
                if (!m_axi_bvalid && sl_wlast_cnt > 0 && sl_aw_ids.size() > 0) begin
                    m_axi_bvalid = 1'b1;
                    m_axi_bid    = sl_aw_ids.pop_front();
                    sl_wlast_cnt--;
                end
                if (r_hs) begin
                    if (m_axi_rlast) begin
                        void'(sl_ar.pop_front());
                        sl_beat = 0;
                    end else sl_beat++;
                end
                if (ar_hs) sl_ar.push_back(ar_info_s);
                if (rd_en && sl_ar.size() > 0) begin
                    m_axi_rvalid = 1'b1;
                    m_axi_rid    = sl_ar[0][40];
                    m_axi_rdata  = rd_pat(sl_ar[0][39:8], 8'(sl_beat));
                    m_axi_rlast  = (8'(sl_beat) == sl_ar[0][7:0]);
                end else m_axi_rvalid = 1'b0;
            end
        end
    end

    task automatic do_aw(input logic id, input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size);
        bit ok = 0;
        s_axi_awid = id; s_axi_awaddr = addr; s_axi_awlen = len; s_axi_awsize = size; s_axi_awvalid = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge uncoreclk);
            ok = s_axi_awready;
        end
        if (!ok) fail_now("aw_timeout", "no awready");
        @(posedge uncoreclk); #1;
        s_axi_awvalid = 1'b0;
    endtask

    task automatic do_w(input int n, input logic [63:0] base);
        for (int b = 0; b < n; b++) begin
            bit ok = 0;
            s_axi_wdata = base + 64'(b); s_axi_wlast = (b == n - 1); s_axi_wvalid = 1'b1;
            for (int i = 0; i < 50 && !ok; i++) begin
                @(negedge uncoreclk);
                ok = s_axi_wready;
            end
            if (!ok) fail_now("w_timeout", "no wready");
            @(posedge uncoreclk); #1;
        end
        s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
    endtask

    task automatic do_ar(input logic id, input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size);
        bit ok = 0;
        s_axi_arid = id; s_axi_araddr = addr; s_axi_arlen = len; s_axi_arsize = size; s_axi_arvalid = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge uncoreclk);
            ok = s_axi_arready;
        end
        if (!ok) fail_now("ar_timeout", "no arready");
        @(posedge uncoreclk); #1;
        s_axi_arvalid = 1'b0;
    endtask

    task automatic wr_legal(input logic id, input logic [31:0] addr, input logic [7:0] len);
        logic [63:0] base = {32'hD00D_0000, addr};
        exp_maw.push_back(addr);
        for (int b = 0; b <= int'(len); b++) exp_mw.push_back(base + 64'(b));
        exp_b.push_back({id, 2'b00});
        $display("write legal   id=%0d addr=%h len=%0d", id, addr, len);
        do_aw(id, addr, len, 3'd3);
        do_w(int'(len) + 1, base);
    endtask

    task automatic wr_illegal(input logic id, input logic [31:0] addr, input logic [7:0] len);
        exp_b.push_back({id, 2'b11});
        $display("write reject  id=%0d addr=%h len=%0d", id, addr, len);
        do_aw(id, addr, len, 3'd3);
        do_w(int'(len) + 1, 64'hBAD0);
    endtask

    task automatic rd_push(input logic id, input logic [31:0] addr, input logic [7:0] len, input bit legal);
        for (int b = 0; b <= int'(len); b++)
            exp_r.push_back({id, legal ? rd_pat(addr, 8'(b)) : 64'd0, legal ? 2'b00 : 2'b11, b == int'(len)});
        $display("read  %s id=%0d addr=%h len=%0d", legal ? "legal " : "reject", id, addr, len);
        do_ar(id, addr, len, 3'd3);
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 400; i++) begin
            if (exp_maw.size() == 0 && exp_mw.size() == 0 && exp_b.size() == 0 && exp_r.size() == 0) break;
            @(negedge uncoreclk);
        end
        if (exp_maw.size() + exp_mw.size() + exp_b.size() + exp_r.size() != 0)
            fail_now(name, $sformatf("%0d responses still pending", exp_maw.size() + exp_mw.size() + exp_b.size() + exp_r.size()));
        @(posedge uncoreclk); #1;
    endtask

    function automatic logic [9:0] hs_vec();
        return {s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready, s_axi_rvalid,
                m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready};
    endfunction

    initial begin
        s_axi_awid = 0; s_axi_awaddr = 0; s_axi_awlen = 0; s_axi_awsize = 3; s_axi_awburst = 2'b01; s_axi_awvalid = 0;
        s_axi_wdata = 0; s_axi_wstrb = 8'hFF; s_axi_wlast = 0; s_axi_wvalid = 0; s_axi_bready = 1;
        s_axi_arid = 0; s_axi_araddr = 0; s_axi_arlen = 0; s_axi_arsize = 3; s_axi_arburst = 2'b01; s_axi_arvalid = 0;
        s_axi_rready = 1;
        repeat (3) @(posedge uncoreclk);
        #1;
        chk("reset_handshakes", 128'(hs_vec()), 128'(0));
        chk("reset_err_log", 128'({err_count, err_addr, err_is_write}), 128'(0));
        uncore_rstn = 1'b1;
        @(posedge uncoreclk); #1;

        // 1: legal 4-beat write passes through with downstream OKAY
        wr_legal(1'b0, 32'h8000_0000, 8'd3);
        wait_drain("t1_drain");
        chk("t1_err_count", 128'(err_count), 128'(0));

        // 2: out-of-window write answered locally one cycle after wlast
        wr_illegal(1'b1, 32'h9000_0000, 8'd0);
        @(negedge uncoreclk);
        chk("t2_b_latency", 128'(s_axi_bvalid), 128'(1));
        wait_drain("t2_drain");
        chk("t2_err_log", 128'({err_count, err_addr, err_is_write}), 128'({16'd1, 32'h9000_0000, 1'b1}));

        // 3: read crossing the window end, plus a read ending exactly on the end
        rd_push(1'b0, 32'h8FFF_FFF8, 8'd1, 1'b0);
        @(negedge uncoreclk);
        chk("t3_r_latency", 128'(s_axi_rvalid), 128'(1));
        wait_drain("t3_drain");
        chk("t3_err_log", 128'({err_count, err_addr, err_is_write}), 128'({16'd2, 32'h8FFF_FFF8, 1'b0}));
        rd_push(1'b1, 32'h8FFF_FFF0, 8'd1, 1'b1);
        wait_drain("t3_edge_drain");
        chk("t3_edge_err_count", 128'(err_count), 128'(2));

        // 4: eight outstanding reads block a ninth and hold back the DECERR beats
        rd_en = 1'b0;
        for (int i = 0; i < 8; i++) rd_push(1'b0, 32'h8000_0000 + 32'(i) * 32'h100, 8'd1, 1'b1);
        s_axi_arid = 0; s_axi_araddr = 32'h8000_1000; s_axi_arlen = 0; s_axi_arvalid = 1'b1;
        repeat (4) begin
            @(negedge uncoreclk);
            chk("t4_ar_stall", 128'({s_axi_arready, m_axi_arvalid}), 128'(0));
        end
        @(posedge uncoreclk); #1;
        s_axi_arvalid = 1'b0;
        rd_push(1'b1, 32'h1000_0000, 8'd0, 1'b0);
        repeat (5) begin
            @(negedge uncoreclk);
            chk("t4_r_withheld", 128'(s_axi_rvalid), 128'(0));
        end
        @(posedge uncoreclk); #1;
        rd_en = 1'b1;
        wait_drain("t4_drain");
        chk("t4_err_count", 128'(err_count), 128'(3));

        // 5: asynchronous reset in the middle of draining a rejected write
        $display("write reject  id=0 addr=00000000 len=3 (reset mid-drain)");
        do_aw(1'b0, 32'h0000_0000, 8'd3, 3'd3);
        s_axi_wdata = 64'h1; s_axi_wlast = 1'b0; s_axi_wvalid = 1'b1;
        @(negedge uncoreclk);
        chk("t5_drain_wready", 128'(s_axi_wready), 128'(1));
        @(posedge uncoreclk); #1;
        s_axi_awaddr = 32'h8000_2000; s_axi_awvalid = 1'b1;
        s_axi_araddr = 32'h8000_2000; s_axi_arvalid = 1'b1;
        uncore_rstn = 1'b0;
        #1;
        chk("t5_reset_handshakes", 128'(hs_vec()), 128'(0));
        chk("t5_reset_err_log", 128'({err_count, err_addr, err_is_write}), 128'(0));
        @(negedge uncoreclk);
        chk("t5_reset_hold", 128'(hs_vec()), 128'(0));
        s_axi_awvalid = 1'b0; s_axi_arvalid = 1'b0; s_axi_wvalid = 1'b0;
        @(posedge uncoreclk); #1;
        uncore_rstn = 1'b1;
        @(posedge uncoreclk); #1;
        wr_legal(1'b1, 32'h8000_1000, 8'd1);
        wait_drain("t5_drain");
        chk("t5_err_count", 128'(err_count), 128'(0));

        // 6: upstream stalls in the middle of a DECERR read burst
        s_axi_rready = 1'b0;
        rd_push(1'b0, 32'h0000_0040, 8'd2, 1'b0);
        begin
            bit seen = 0;
            for (int i = 0; i < 20 && !seen; i++) begin
                @(negedge uncoreclk);
                seen = s_axi_rvalid;
            end
            if (!seen) fail_now("t6_rvalid_timeout", "no rvalid");
        end
        repeat (5) begin
            @(negedge uncoreclk);
            chk("t6_r_hold", 128'({s_axi_rvalid, s_axi_rdata, s_axi_rresp, s_axi_rlast}), 128'({1'b1, 64'd0, 2'b11, 1'b0}));
        end
        @(posedge uncoreclk); #1;
        s_axi_rready = 1'b1;
        wait_drain("t6_drain");
        chk("t6_err_log", 128'({err_count, err_addr, err_is_write}), 128'({16'd1, 32'h0000_0040, 1'b0}));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
